clipper_fan_ctrl: RTL and testbench

//  DUT-side fan controller for the misc I/O fan signals. It drives fan_enable and fan_ctrl (PWM) toward the hardware.
//  It also measures the fan_tach pulses coming back from the hardware and flags stalled fans.
//  It sits between the CPU-visible register block (cfg_*, status outputs) and the fan pins of the misc I/O interface.

---
 rtl/clipper_pkg.sv | 19 +
 rtl/clipper_fan_tach_meas.sv | 117 +++++++++++
 rtl/clipper_fan_ctrl.sv | 169 ++++++++++++++++
 tb/tb_clipper_fan_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clipper_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clipper_pkg
// Purpose  : Shared constants and types for the clipper misc-I/O fan logic.
// Contents : NB_FANS, FAN_DUTY_W, PWM_STEPS, fan_duty_t, fan_duty_arr_t
// Revision : 1.0 - initial release
// ============================================================================
package clipper_pkg;

   localparam int NB_FANS    = 2;
   localparam int FAN_DUTY_W = 8;
   // Number of pwm_cnt steps per PWM period (counter runs 0..PWM_STEPS-1).
   localparam int PWM_STEPS  = 255;

   typedef logic [FAN_DUTY_W-1:0] fan_duty_t;
   typedef fan_duty_t [NB_FANS-1:0] fan_duty_arr_t;

endpackage : clipper_pkg
`default_nettype wire

// File: rtl/clipper_fan_tach_meas.sv
`default_nettype none
// ============================================================================
// Module   : clipper_fan_tach_meas
// Purpose  : Tachometer period measurement and stall detection for one fan.
//            fan_tach_i is synchronised (2 FF), rising edges are detected
//            against a third register, and the clk cycles between two
//            consecutive edges are reported. No edge within STALL_TIMEOUT
//            cycles flags a stall.
// Ports    : clk          in   system clock
//            rst_n        in   asynchronous reset, active-low
//            mon_en_i     in   monitoring gate (fan powered and duty != 0)
//            fan_tach_i   in   raw tachometer input (asynchronous)
//            period_o     out  cycles between consecutive rising edges
//            valid_o      out  period_o holds a valid measurement
//            stall_o      out  no edge seen within STALL_TIMEOUT cycles
// Revision : 1.0 - initial release
// ============================================================================
module clipper_fan_tach_meas #(
   parameter int TACH_W        = 24,
   parameter int STALL_TIMEOUT = 12_500_000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mon_en_i,
   input  logic              fan_tach_i,
   output logic [TACH_W-1:0] period_o,
   output logic              valid_o,
   output logic              stall_o
);

   localparam logic [TACH_W-1:0] C_TIMEOUT    = TACH_W'(STALL_TIMEOUT);
   localparam logic [TACH_W-1:0] C_TIMEOUT_M1 = TACH_W'(STALL_TIMEOUT - 1);

   logic              tach_meta_q;
   logic              tach_sync_q;
   logic              tach_prev_q;
   logic              rise;

   logic [TACH_W-1:0] cnt_q,    cnt_d;
   logic              armed_q,  armed_d;
   logic [TACH_W-1:0] period_q, period_d;
   logic              valid_q,  valid_d;
   logic              stall_q,  stall_d;

   // Synchroniser and edge-detect stage run regardless of the gate so that a
   // tach line already high when monitoring opens is not seen as an edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tach_meta_q <= 1'b0;
         tach_sync_q <= 1'b0;
         tach_prev_q <= 1'b0;
      end else begin
         tach_meta_q <= fan_tach_i;
         tach_sync_q <= tach_meta_q;
         tach_prev_q <= tach_sync_q;
      end
   end

   assign rise = tach_sync_q & ~tach_prev_q;

   always_comb begin
      cnt_d    = cnt_q;
      armed_d  = armed_q;
      period_d = period_q;
      valid_d  = valid_q;
      stall_d  = stall_q;

      if (!mon_en_i) begin
         // Gated: forget everything except the last reported period.
         cnt_d   = '0;
         armed_d = 1'b0;
         valid_d = 1'b0;
         stall_d = 1'b0;
      end else begin
         if (cnt_q != C_TIMEOUT) begin
            cnt_d = cnt_q + TACH_W'(1);
         end
         // An edge on the timeout cycle takes priority over the stall.
         if (rise) begin
            cnt_d   = '0;
            armed_d = 1'b1;
            if (armed_q) begin
               period_d = cnt_q + TACH_W'(1);
               valid_d  = 1'b1;
               stall_d  = 1'b0;
            end
         end else if (cnt_q == C_TIMEOUT_M1) begin
            stall_d  = 1'b1;
            valid_d  = 1'b0;
            period_d = '1;
            armed_d  = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         armed_q  <= 1'b0;
         period_q <= '0;
         valid_q  <= 1'b0;
         stall_q  <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         armed_q  <= armed_d;
         period_q <= period_d;
         valid_q  <= valid_d;
         stall_q  <= stall_d;
      end
   end

   assign period_o = period_q;
   assign valid_o  = valid_q;
   assign stall_o  = stall_q;

endmodule : clipper_fan_tach_meas
`default_nettype wire

// File: rtl/clipper_fan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clipper_fan_ctrl
// Purpose  : Fan controller for the misc I/O fan pins. Drives fan_enable and a
//            per-fan PWM (fan_ctrl), measures tachometer periods and flags
//            stalled fans. Sits between the CPU register block and the pins.
// Ports    : clk            in   system clock
//            rst_n          in   asynchronous reset, active-low
//            cfg_enable     in   global fan enable
//            cfg_duty       in   NB_FANS x 8 duty (0 = off, 255 = full on)
//            fan_tach       in   NB_FANS raw tachometer inputs (async)
//            fan_enable     out  fan power enable (cfg_enable, 1 cycle later)
//            fan_ctrl       out  NB_FANS PWM outputs
//            tach_period    out  NB_FANS x TACH_W measured tach periods
//            tach_valid     out  NB_FANS period-valid flags
//            fan_stall      out  NB_FANS stall flags
//            stall_irq      out  sticky stall interrupt   (FAN_STALL_IRQ_EN)
//            stall_irq_clr  in   single-cycle IRQ clear   (FAN_STALL_IRQ_EN)
// Config   : define FAN_STALL_IRQ_EN to add the stall interrupt and its ports.
// Revision : 1.0 - initial release
// ============================================================================
module clipper_fan_ctrl
   import clipper_pkg::*;
#(
   parameter int NB_FANS       = clipper_pkg::NB_FANS,
   parameter int PWM_PRESC     = 49,
   parameter int TACH_W        = 24,
   parameter int STALL_TIMEOUT = 12_500_000
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        cfg_enable,
   input  logic [NB_FANS*FAN_DUTY_W-1:0] cfg_duty,
   input  logic [NB_FANS-1:0]          fan_tach,
   output logic                        fan_enable,
   output logic [NB_FANS-1:0]          fan_ctrl,
   output logic [NB_FANS*TACH_W-1:0]   tach_period,
   output logic [NB_FANS-1:0]          tach_valid,
   output logic [NB_FANS-1:0]          fan_stall
`ifdef FAN_STALL_IRQ_EN
   ,
   output logic                        stall_irq,
   input  logic                        stall_irq_clr
`endif
);

   localparam int PRESC_W = (PWM_PRESC > 0) ? $clog2(PWM_PRESC + 1) : 1;
   localparam logic [PRESC_W-1:0]    C_PRESC_MAX = PRESC_W'(PWM_PRESC);
   localparam logic [FAN_DUTY_W-1:0] C_PWM_LAST  = FAN_DUTY_W'(PWM_STEPS - 1);

   logic                      fan_enable_q;
   logic [PRESC_W-1:0]        presc_q,   presc_d;
   logic [FAN_DUTY_W-1:0]     pwm_cnt_q, pwm_cnt_d;
   fan_duty_t [NB_FANS-1:0]   duty_q,    duty_d;
   logic [NB_FANS-1:0]        fan_ctrl_q, fan_ctrl_d;
   fan_duty_t [NB_FANS-1:0]   cfg_duty_arr;
   logic [NB_FANS-1:0]        mon_en;
   logic [NB_FANS-1:0]        stall;

   assign cfg_duty_arr = cfg_duty;

   // ------------------------------------------------------------------------
   // Prescaler, PWM counter, duty latch and compare
   // ------------------------------------------------------------------------
   always_comb begin
      presc_d    = presc_q;
      pwm_cnt_d  = pwm_cnt_q;
      duty_d     = duty_q;
      fan_ctrl_d = '0;

      if (!cfg_enable) begin
         // Held at the start of a period; tracking the duty while disabled
         // means the first period after re-enable uses the current setting.
         presc_d   = '0;
         pwm_cnt_d = '0;
         duty_d    = cfg_duty_arr;
      end else if (presc_q == C_PRESC_MAX) begin
         presc_d = '0;
         if (pwm_cnt_q == C_PWM_LAST) begin
            // Duty only changes at a period boundary: glitch-free output.
            pwm_cnt_d = '0;
            duty_d    = cfg_duty_arr;
         end else begin
            pwm_cnt_d = pwm_cnt_q + FAN_DUTY_W'(1);
         end
      end else begin
         presc_d = presc_q + PRESC_W'(1);
      end

      for (int i = 0; i < NB_FANS; i++) begin
         fan_ctrl_d[i] = cfg_enable && (pwm_cnt_q < duty_q[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fan_enable_q <= 1'b0;
         presc_q      <= '0;
         pwm_cnt_q    <= '0;
         duty_q       <= '0;
         fan_ctrl_q   <= '0;
      end else begin
         fan_enable_q <= cfg_enable;
         presc_q      <= presc_d;
         pwm_cnt_q    <= pwm_cnt_d;
         duty_q       <= duty_d;
         fan_ctrl_q   <= fan_ctrl_d;
      end
   end

   assign fan_enable = fan_enable_q;
   assign fan_ctrl   = fan_ctrl_q;

   // ------------------------------------------------------------------------
   // Per-fan tach measurement
   // ------------------------------------------------------------------------
   for (genvar gi = 0; gi < NB_FANS; gi++) begin : g_fan
      // A fan that is unpowered or driven at duty 0 is not expected to spin.
      assign mon_en[gi] = fan_enable_q && (duty_q[gi] != '0);

      clipper_fan_tach_meas #(
         .TACH_W        (TACH_W),
         .STALL_TIMEOUT (STALL_TIMEOUT)
      ) u_tach_meas (
         .clk        (clk),
         .rst_n      (rst_n),
         .mon_en_i   (mon_en[gi]),
         .fan_tach_i (fan_tach[gi]),
         .period_o   (tach_period[gi*TACH_W +: TACH_W]),
         .valid_o    (tach_valid[gi]),
         .stall_o    (stall[gi])
      );
   end : g_fan

   assign fan_stall = stall;

   // ------------------------------------------------------------------------
   // Optional sticky stall interrupt
   // ------------------------------------------------------------------------
`ifdef FAN_STALL_IRQ_EN
   logic [NB_FANS-1:0] stall_prev_q;
   logic               stall_irq_q, stall_irq_d;

   always_comb begin
      stall_irq_d = stall_irq_q;
      if (stall_irq_clr) begin
         stall_irq_d = 1'b0;
      end
      // Set is evaluated last so it wins over a coincident clear.
      if (|(stall & ~stall_prev_q)) begin
         stall_irq_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_prev_q <= '0;
         stall_irq_q  <= 1'b0;
      end else begin
         stall_prev_q <= stall;
         stall_irq_q  <= stall_irq_d;
      end
   end

   assign stall_irq = stall_irq_q;
`endif

endmodule : clipper_fan_ctrl
`default_nettype wire

// File: tb/tb_clipper_fan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clipper_fan_ctrl
// Purpose  : Directed self-checking bench for clipper_fan_ctrl
//            (PWM_PRESC=0, STALL_TIMEOUT=1000, NB_FANS=2).
// Config   : define FAN_STALL_IRQ_EN to also exercise the stall interrupt.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_clipper_fan_ctrl;

   localparam int NB = 2;
   localparam int TW = 24;
   localparam int TO = 1000;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            cfg_enable;
   logic [NB*8-1:0] cfg_duty;
   logic [NB-1:0]   fan_tach;
   logic            fan_enable;
   logic [NB-1:0]   fan_ctrl;
   logic [NB*TW-1:0] tach_period;
   logic [NB-1:0]   tach_valid;
   logic [NB-1:0]   fan_stall;
`ifdef FAN_STALL_IRQ_EN
   logic            stall_irq;
   logic            stall_irq_clr;
`endif

   int checks = 0;
   int errors = 0;
   int k      = 0;   // cycles since cfg_enable was raised
   int hi;
   int bad;

   clipper_fan_ctrl #(
      .NB_FANS       (NB),
      .PWM_PRESC     (0),
      .TACH_W        (TW),
      .STALL_TIMEOUT (TO)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cfg_enable  (cfg_enable),
      .cfg_duty    (cfg_duty),
      .fan_tach    (fan_tach),
      .fan_enable  (fan_enable),
      .fan_ctrl    (fan_ctrl),
      .tach_period (tach_period),
      .tach_valid  (tach_valid),
      .fan_stall   (fan_stall)
`ifdef FAN_STALL_IRQ_EN
      ,
      .stall_irq     (stall_irq),
      .stall_irq_clr (stall_irq_clr)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      k++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Raise fan_tach[0]; the measurement outputs update 3 edges later.
   task automatic rise();
      fan_tach[0] = 1'b1;
      repeat (3) tick();
   endtask

   // Complete a tach cycle started by rise(): total gap of n cycles to the
   // next rise() call.
   task automatic finish_period(input int n);
      repeat (7) tick();
      fan_tach[0] = 1'b0;
      repeat (n - 10) tick();
   endtask

   initial begin
      rst_n      = 1'b0;
      cfg_enable = 1'b0;
      cfg_duty   = {8'd255, 8'd0};
      fan_tach   = '0;
`ifdef FAN_STALL_IRQ_EN
      stall_irq_clr = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      // ---------------- reset state ----------------
      chk("rst_fan_enable", 32'(fan_enable), 32'd0);
      chk("rst_fan_ctrl",   32'(fan_ctrl),   32'd0);
      chk("rst_period0",    32'(tach_period[TW-1:0]), 32'd0);
      chk("rst_valid",      32'(tach_valid), 32'd0);
      chk("rst_stall",      32'(fan_stall),  32'd0);
`ifdef FAN_STALL_IRQ_EN
      chk("rst_irq",        32'(stall_irq),  32'd0);
`endif
      rst_n = 1'b1;
      repeat (3) tick();

      // ---------------- 1: enable, duty {255,0} ----------------
      k = 0;
      cfg_enable = 1'b1;
      chk("en_latency_pre", 32'(fan_enable), 32'd0);
      tick();
      chk("en_latency_post", 32'(fan_enable), 32'd1);
      chk("ctrl_0_255", 32'(fan_ctrl), 32'b10);
      bad = 0;
      repeat (299) begin
         tick();
         if (fan_ctrl !== 2'b10) bad++;
      end
      chk("ctrl_const_cycles_bad", 32'(bad), 32'd0);

      // ---------------- 2: duty 64, then 128 mid-period ----------------
      cfg_duty[7:0] = 8'd64;              // k = 300, latched at k = 510
      repeat (210) tick();
      hi = 0;
      repeat (255) begin
         tick();
         if (fan_ctrl[0]) hi++;
         if (k == 574) chk("duty64_last_high", 32'(fan_ctrl[0]), 32'd1);
         if (k == 575) chk("duty64_first_low", 32'(fan_ctrl[0]), 32'd0);
      end
      chk("duty64_high_count", 32'(hi), 32'd64);
      hi = 0;
      repeat (255) begin
         tick();
         if (fan_ctrl[0]) hi++;
         if (k == 800) cfg_duty[7:0] = 8'd128;
      end
      chk("duty_change_keeps_64", 32'(hi), 32'd64);
      hi = 0;
      repeat (255) begin
         tick();
         if (fan_ctrl[0]) hi++;
      end
      chk("duty128_high_count", 32'(hi), 32'd128);
      // Fan 1 has been monitored since enable and never saw an edge.
      chk("fan1_stalled_fan0_not", 32'(fan_stall), 32'b10);

      // ---------------- 3: tach every 400 cycles ----------------
`ifdef FAN_STALL_IRQ_EN
      stall_irq_clr = 1'b1;
      tick();
      stall_irq_clr = 1'b0;
      tick();
      chk("irq_cleared", 32'(stall_irq), 32'd0);
`endif
      cfg_duty[7:0] = 8'd100;
      rise();
      chk("first_edge_no_valid", 32'(tach_valid[0]), 32'd0);
      finish_period(400);
      for (int e = 0; e < 2; e++) begin
         rise();
         chk("period_400", 32'(tach_period[TW-1:0]), 32'd400);
         chk("valid_400",  32'(tach_valid[0]), 32'd1);
         finish_period(400);
      end
      rise();
      chk("period_400_last", 32'(tach_period[TW-1:0]), 32'd400);

      // ---------------- 4: stop edges -> stall at 1000 ----------------
      repeat (7) tick();
      fan_tach[0] = 1'b0;
      repeat (992) tick();
      chk("stall_not_yet", 32'(fan_stall[0]), 32'd0);
      tick();
      chk("stall_at_1000",  32'(fan_stall[0]), 32'd1);
      chk("stall_valid",    32'(tach_valid[0]), 32'd0);
      chk("stall_period",   32'(tach_period[TW-1:0]), 32'h00FF_FFFF);
`ifdef FAN_STALL_IRQ_EN
      tick();
      chk("irq_set", 32'(stall_irq), 32'd1);
      stall_irq_clr = 1'b1;
      tick();
      stall_irq_clr = 1'b0;
      chk("irq_clr", 32'(stall_irq), 32'd0);
`endif
      rise();
      chk("resume_1st_still_stall", 32'(fan_stall[0]), 32'd1);
      finish_period(400);
      rise();
      chk("resume_2nd_stall_clr", 32'(fan_stall[0]), 32'd0);
      chk("resume_2nd_period", 32'(tach_period[TW-1:0]), 32'd400);

      // ---------------- 5: edge on the timeout cycle ----------------
      finish_period(1000);
      rise();
      chk("timeout_edge_period", 32'(tach_period[TW-1:0]), 32'd1000);
      chk("timeout_edge_nostall", 32'(fan_stall[0]), 32'd0);
      chk("timeout_edge_valid", 32'(tach_valid[0]), 32'd1);
      repeat (7) tick();
      fan_tach[0] = 1'b0;
      repeat (993) tick();
      chk("stall_again", 32'(fan_stall[0]), 32'd1);
`ifdef FAN_STALL_IRQ_EN
      // Set (one cycle after the stall rises) coincides with a clear.
      stall_irq_clr = 1'b1;
      tick();
      stall_irq_clr = 1'b0;
      chk("irq_set_beats_clr", 32'(stall_irq), 32'd1);
`endif
      cfg_duty[7:0] = 8'd0;
      do tick(); while (k % 255 != 0);   // duty 0 latched on this edge
      tick();
      chk("gated_stall_clr", 32'(fan_stall[0]), 32'd0);
      chk("gated_valid",     32'(tach_valid[0]), 32'd0);
      repeat (1500) tick();
      chk("gated_no_timeout", 32'(fan_stall[0]), 32'd0);
      chk("gated_period_held", 32'(tach_period[TW-1:0]), 32'h00FF_FFFF);

      // ---------------- 6: asynchronous reset mid-period ----------------
      chk("pre_reset_ctrl1", 32'(fan_ctrl[1]), 32'd1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_rst_enable", 32'(fan_enable), 32'd0);
      chk("async_rst_ctrl",   32'(fan_ctrl),   32'd0);
      chk("async_rst_period", 32'(tach_period[TW-1:0]), 32'd0);
      chk("async_rst_stall",  32'(fan_stall),  32'd0);
`ifdef FAN_STALL_IRQ_EN
      chk("async_rst_irq",    32'(stall_irq),  32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_clipper_fan_ctrl
`default_nettype wire
